// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car and its neighbouring timers.
package elevator_pkg;

    typedef enum logic [1:0] {
        CAR_IDLE = 2'b00,
        CAR_MOVE = 2'b01,
        CAR_DOOR = 2'b10
    } car_state_t;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int floor_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elevator_car_if.sv
// Car <-> request queue / indicator bundle; master is the queue/display side.
interface elevator_car_if #(
    parameter int NUM_FLOORS = 8
) ();
    import elevator_pkg::*;

    localparam int FW = floor_w(NUM_FLOORS);

    logic [FW-1:0]         default_floor;
    logic [NUM_FLOORS-1:0] req;
    logic [NUM_FLOORS-1:0] clear_req;
    logic [FW-1:0]         current_floor;
    logic                  current_up_ndown;
    logic                  moving;
    logic                  door_open;
    car_state_t            state;

    modport master (
        output default_floor, req,
        input  clear_req, current_floor, current_up_ndown, moving, door_open, state
    );

    modport slave (
        input  default_floor, req,
        output clear_req, current_floor, current_up_ndown, moving, door_open, state
    );

endinterface

// File: rtl/elevator_car_tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module tick_divider
    import elevator_pkg::*;
#(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = floor_w(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/elevator_car.sv
// SCAN-style elevator car: serves the level-held request vector, dwells with
// the door open per stop, and homes to default_floor when nothing is pending.
module elevator_car
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int TICK_DIV   = 1000000,
    parameter int DOOR_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    elevator_car_if.slave bus
);
    localparam int FW = floor_w(NUM_FLOORS);
    localparam int DW = floor_w(DOOR_TICKS + 1);
    localparam logic [FW-1:0] TOP = FW'(NUM_FLOORS - 1);

    logic tick;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    car_state_t            state_q;
    logic [FW-1:0]         floor_q;
    logic                  up_q, moving_q, door_q;
    logic [NUM_FLOORS-1:0] clear_q;
    logic [DW-1:0]         door_cnt;

    logic [NUM_FLOORS-1:0] here_mask;
    logic                  here, above, below, ahead, behind, at_end;
    logic [FW-1:0]         home;

    always_comb begin
        here_mask = '0;
        above     = 1'b0;
        below     = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            here_mask[i] = (i == int'(floor_q));
            if (i > int'(floor_q)) above |= bus.req[i];
            if (i < int'(floor_q)) below |= bus.req[i];
        end
        here   = |(bus.req & here_mask);
        ahead  = up_q ? above : below;
        behind = up_q ? below : above;
        at_end = up_q ? (floor_q == TOP) : (floor_q == '0);
        home   = (int'(bus.default_floor) >= NUM_FLOORS) ? TOP : bus.default_floor;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= CAR_IDLE;
            floor_q  <= '0;
            up_q     <= 1'b1;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
            clear_q  <= '0;
            door_cnt <= '0;
        end else begin
            clear_q <= '0;
            case (state_q)
                CAR_IDLE: begin
                    if (here) begin
                        state_q  <= CAR_DOOR;
                        moving_q <= 1'b0;
                        door_q   <= 1'b1;
                        door_cnt <= DW'(DOOR_TICKS);
                        clear_q  <= here_mask;
                    end else if (ahead) begin
                        state_q  <= CAR_MOVE;
                        moving_q <= 1'b1;
                    end else if (behind) begin
                        up_q     <= ~up_q;
                        state_q  <= CAR_MOVE;
                        moving_q <= 1'b1;
                    end else if (floor_q != home) begin
                        // Homing stays in IDLE so a new request wins next cycle.
                        up_q     <= (home > floor_q);
                        moving_q <= 1'b1;
                        if (tick)
                            floor_q <= (home > floor_q) ? floor_q + FW'(1) : floor_q - FW'(1);
                    end else begin
                        moving_q <= 1'b0;
                    end
                end
                CAR_MOVE: begin
                    if (tick) begin
                        if (at_end) begin
                            state_q  <= CAR_IDLE;
                            moving_q <= 1'b0;
                        end else begin
                            floor_q <= up_q ? floor_q + FW'(1) : floor_q - FW'(1);
                        end
                    end else if (here) begin
                        state_q  <= CAR_DOOR;
                        moving_q <= 1'b0;
                        door_q   <= 1'b1;
                        door_cnt <= DW'(DOOR_TICKS);
                        clear_q  <= here_mask;
                    end else if (!ahead && behind) begin
                        up_q <= ~up_q;
                    end else if (!ahead) begin
                        state_q  <= CAR_IDLE;
                        moving_q <= 1'b0;
                    end
                end
                CAR_DOOR: begin
                    // A fresh call at the open floor is absorbed without extending dwell.
                    if (here) clear_q <= here_mask;
                    if (tick) begin
                        if (door_cnt <= DW'(1)) begin
                            door_cnt <= '0;
                            door_q   <= 1'b0;
                            if (ahead) begin
                                state_q  <= CAR_MOVE;
                                moving_q <= 1'b1;
                            end else if (behind) begin
                                up_q     <= ~up_q;
                                state_q  <= CAR_MOVE;
                                moving_q <= 1'b1;
                            end else begin
                                state_q <= CAR_IDLE;
                            end
                        end else begin
                            door_cnt <= door_cnt - DW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= CAR_IDLE;
                    moving_q <= 1'b0;
                    door_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clear_req        = clear_q;
    assign bus.current_floor    = floor_q;
    assign bus.current_up_ndown = up_q;
    assign bus.moving           = moving_q;
    assign bus.door_open        = door_q;
    assign bus.state            = state_q;

endmodule

// File: doc/elevator_car.md
# elevator_car

Parametrised elevator car controller: it is the next generation of the single-car model, generalised to `NUM_FLOORS` floors. It adds configurable tick division, a timed door dwell, and SCAN-style direction keeping with reversal. It sits between the floor request queue, which supplies a level-held request vector and consumes one-cycle clear pulses, and the indicator/display logic, which consumes floor, direction, motion and door status. When no requests are pending, the car homes to a programmable default floor.

## Interface
- `NUM_FLOORS`, 8: number of floors; must be ≥ 2.
- `TICK_DIV`, 1000000: clk cycles per time unit; must be ≥ 2.
- `DOOR_TICKS`, 3: time units the door stays open per stop; must be ≥ 1.
- `FW` (localparam): `$clog2(NUM_FLOORS)`, the floor index width.
- `clk` input, 1 bit: the single clock, rising edge.
- `reset` input, 1 bit: reset, asynchronous and active-high.
- `default_floor` input, FW bits: home floor; values ≥ `NUM_FLOORS` are treated as `NUM_FLOORS-1`.
- `req` input, NUM_FLOORS bits: pending-request vector from the queue, level-held until cleared.
- `clear_req` output, NUM_FLOORS bits: one-hot, one-cycle pulse telling the queue to drop that floor.
- `current_floor` output, FW bits: car position.
- `current_up_ndown` output, 1 bit: travel direction; 1 = up.
- `moving` output, 1 bit: high in MOVE and while homing.
- `door_open` output, 1 bit: high in DOOR.
- `state` output, 2 bits: `car_state_t` value, for debug.

## Operation
- Tick divider:
  - Free-running counter 0..`TICK_DIV-1`.
  - `tick` is high for one cycle when count == `TICK_DIV-1`; the counter wraps to 0 on that cycle.
  - Reset clears the counter to 0.
- Derived terms, combinational from `req` and `current_floor`:
  - `here` = `req[current_floor]`.
  - `above` = OR of `req` bits above `current_floor`.
  - `below` = OR of `req` bits below `current_floor`.
  - `ahead` = `above` if `current_up_ndown` is 1, else `below`.
  - `behind` = the other of the two.
- IDLE:
  - If `here`: go to DOOR.
  - Else if `ahead`: go to MOVE, keeping direction.
  - Else if `behind`: invert direction, then go to MOVE.
  - Else if `current_floor` != clamped `default_floor`: homing. Set direction toward home, assert `moving`, and step ±1 on each `tick`. Stay in IDLE, so any new request preempts homing on the next cycle.
  - Else: hold, with `moving` = 0.
- MOVE:
  - On `tick`: step ±1 in `current_up_ndown`.
  - On non-tick cycles:
    - If `here`: go to DOOR.
    - Else if not `ahead` and `behind`: reverse direction.
    - Else if neither: go to IDLE.
- DOOR:
  - On entry: load the door counter with `DOOR_TICKS` and pulse `clear_req[current_floor]`.
  - While in DOOR: any cycle `here` reasserts, pulse `clear_req` again (absorbs a new call at the open floor); this does not reload the counter.
  - On each `tick`: decrement the counter.
  - On the `tick` where the counter reaches 0, the next state follows the IDLE decision order, excluding homing:
    - `ahead` goes to MOVE.
    - `behind` goes to MOVE with direction inverted.
    - Otherwise go to IDLE.
- Bounds:
  - At floor 0 going down, or at floor `NUM_FLOORS-1` going up, the step is suppressed and the car goes to IDLE. This cannot occur with legal `req`, but the guard is mandatory.
  - `req` bits are ignored while the car is in DOOR at a different floor: the car is stationary.
- Simultaneous events: when `here` and `ahead` are both true in IDLE, DOOR wins.

## Timing
- Reset values:
  - state = IDLE.
  - `current_floor` = 0.
  - `current_up_ndown` = 1.
  - `moving` = 0, `door_open` = 0, `clear_req` = 0.
  - Door counter = 0, divider = 0.
- After reset, the car homes to `default_floor` on ticks.
- Reset asserted mid-operation returns all outputs to reset values immediately, without waiting for a clock edge.
- All outputs are registered. `moving` and `door_open` are registered alongside the state, so they change on the same edge as the state.
- Request to response:
  - IDLE to DOOR: 1 cycle.
  - IDLE to MOVE: 1 cycle.
  - Each floor step occurs on a `tick` edge.
- `clear_req` asserts on the same edge that enters DOOR.
- Door dwell: `DOOR_TICKS` ticks, so its length varies by < 1 tick depending on divider phase at entry.

## Structure
- `elevator_pkg`:
  - `car_state_t` enum: `CAR_IDLE`=2'b00, `CAR_MOVE`=2'b01, `CAR_DOOR`=2'b10.
  - Floor-width helper function.
- Sub-module `tick_divider #(TICK_DIV)`: ports `clk`, `reset`, `tick`. It is reused by the queue and display timers.
- Main FSM and request reduction live in `elevator_car`.

## Test plan
Setup: `NUM_FLOORS`=8, `TICK_DIV`=4, `DOOR_TICKS`=2.
- Reset, then `default_floor`=3 with `req`=0 → `moving`=1, up; floor reaches 3 after 3 ticks; then `moving`=0.
- At floor 3, `req`=8'h08 → next cycle `door_open`=1 and `clear_req`=8'h08; DOOR exits after 2 ticks.
- At floor 0, `req`=8'h24 (floors 2 and 5) → stops at 2 then 5, going up throughout; a `clear_req` pulse at each stop.
- At floor 5 with the door open, direction up, `req`=8'h02 → after dwell, direction flips to 0 and the car travels to floor 1.
- While homing from 6 toward 0, `req`=8'h80 raised at floor 4 → direction reverses, car returns to 7 and opens the door.
- Reset asserted during MOVE between ticks → outputs go to reset values immediately; floor = 0.
